vga_motion_zone_detector: RTL and testbench
===========================================

// Module: vga_motion_zone_detector
// PURPOSE
//  Downstream of the VGA timing decoder. Consumes its pixel-enable, DE and x/y coordinates plus the RGB565 pixel.
//  Detects frame-to-frame motion in a 4x3 grid of 160x160 zones over the 640x480 visible area.
//  Keeps a 160x120 8-bit luma copy of the previous frame and counts changed samples per zone.
//  Publishes 12 motion flags and a done pulse once per frame, for game logic to read as player hits.
// PARAMETERS
//  DIFF_TH   24   |Ycur-Yprev| strictly greater than this marks a sample as changed
//  COUNT_TH  64   a zone is flagged when changed samples >= COUNT_TH (max 1600 samples per zone)
//  CNT_W     11   zone counter width; counters saturate at 2^CNT_W-1
// PORTS
//  clk           in   1   system clock (pixel rate x4)
//  reset         in   1   asynchronous, active-high
//  pclk          in   1   pixel enable, one clk-wide pulse every 4 clk, from the decoder
//  DE            in   1   visible-area flag, qualified by pclk
//  x_pixel       in   10  horizontal counter 0..799
//  y_pixel       in   10  vertical counter 0..524
//  rgb           in   16  RGB565 pixel for (x_pixel, y_pixel), valid when pclk & DE
//  motion_flags  out  12  bit i = zone i, where i = row*4+col, row = y/160, col = x/160
//  frame_done    out  1   one-clk pulse when motion_flags is updated
//  diff_pixel    out  1   changed-sample indicator for overlay; registered
// BEHAVIOUR
//  Reset values:
//   - motion_flags=0, frame_done=0, diff_pixel=0.
//   - All zone counters=0, state=S_FIRST.
//   - Luma RAM is not cleared.
//  Sample qualify:
//   - sample = pclk & DE & x[1:0]==0 & y[1:0]==0.
//   - This gives a 4x4 decimation: 160x120 samples per frame.
//  Luma:
//   - Y = {R5,1'b0} + G6 + {B5,1'b0}, 8 bits, range 0..187.
//   - No rounding.
//  Pipeline, with cycle t the qualifying clk:
//   - Cycle t:
//     - compute addr = (y>>2)*160 + (x>>2), range 0..19199;
//     - issue the RAM read;
//     - register Ycur and the zone index.
//   - Cycle t+1:
//     - RAM data is valid;
//     - compute d = |Ycur-Yprev|;
//     - write Ycur to the same addr;
//     - in S_RUN, if d > DIFF_TH, increment that zone's counter (saturating).
//   - diff_pixel:
//     - equals (d > DIFF_TH) from t+2 onward;
//     - forced to 0 in S_FIRST;
//     - holds its value until the next sample.
//  Report event:
//   - trigger: pclk & x_pixel==0 & y_pixel==480.
//   - The last sample, at y=476, has completed long before this.
//  FSM:
//   - S_FIRST:
//     - RAM is written and counters stay 0.
//     - On the report event: frame_done=1 for 1 clk, motion_flags stay 0, go to S_RUN.
//   - S_RUN:
//     - On the report event: motion_flags[i] <= (cnt[i] >= COUNT_TH) for all i.
//     - In the same clk: frame_done=1, all counters cleared to 0.
//     - Stay in S_RUN.
//   - Flags hold between report events.
//  Boundaries:
//   - pclk with DE=0 (blanking, x>=640 or y>=480): no read, no write, no count.
//   - Zone edges: x=159 is col 0, x=160 is col 1; y=319 is row 1, y=320 is row 2.
//   - Report and sample never coincide, because y=480 is outside DE.
//   - Reset mid-frame: state returns to S_FIRST, and the partial frame produces no flags.
//   - Counter saturation: only reachable with CNT_W<11; hold at max, no wrap.
// STRUCTURE
//  Package vga_motion_pkg holds:
//   - H_VISIBLE=640, V_VISIBLE=480, ZONE_SIZE=160, ZONE_COLS=4, ZONE_ROWS=3, DS_W=160, DS_H=120;
//   - typedef enum logic {S_FIRST, S_RUN} motion_state_e.
//  Sub-module frame_luma_ram:
//   - 19200x8 simple dual-port, 1-clk synchronous read, write port separate;
//   - infers BRAM;
//   - same-address read and write never occur in one clk.
//  Top holds: luma calc, address and zone calc, diff/compare, 12 counters, FSM, output registers.
// TESTING
//  1. reset, then a full frame of rgb=0 -> frame_done pulses once at (0,480); motion_flags=0; diff_pixel=0.
//  2. Frame 1 all 0, frame 2 all 16'hFFFF -> Y=187, d=187>24; every counter reaches 1600; motion_flags=12'hFFF.
//  3. Frame 2 changes only x 160..319, y 0..159 -> motion_flags=12'h002; diff_pixel=1 only on those samples.
//  4. Frame 2 changes a 32x32 block at (0,0) -> 64 samples; motion_flags[0]=1.
//     A 28x32 block gives 56 samples -> motion_flags[0]=0.
//  5. Frame 2 raises luma by exactly 24 -> no flag; raised by 25 -> all flags set.
//  6. Assert reset at y=200 of frame 3 -> outputs 0 immediately.
//     Next report event: frame_done=1, motion_flags=0.
//     Following frame reports normally.

Source files
------------

// File: rtl/vga_motion_pkg.sv
// vga_motion_pkg: shared geometry, FSM state type and luma/zone helpers for the motion detector
package vga_motion_pkg;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int ZONE_SIZE = 160;
  localparam int ZONE_COLS = 4;
  localparam int ZONE_ROWS = 3;
  localparam int DS_W = 160;
  localparam int DS_H = 120;
  localparam int N_ZONES = ZONE_COLS * ZONE_ROWS;
  localparam int RAM_DEPTH = DS_W * DS_H;
  localparam int ADDR_W = 15;
  typedef enum logic {S_FIRST, S_RUN} motion_state_e;
  function automatic logic [7:0] rgb565_luma(input logic [15:0] p);
    return {2'b0, p[15:11], 1'b0} + {2'b0, p[10:5]} + {2'b0, p[4:0], 1'b0};
  endfunction
  function automatic logic [1:0] zone_coord(input logic [9:0] v);
    return v >= 10'(3 * ZONE_SIZE) ? 2'd3 : v >= 10'(2 * ZONE_SIZE) ? 2'd2 : v >= 10'(ZONE_SIZE) ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/frame_luma_ram.sv
// frame_luma_ram: 19200x8 simple dual-port luma store, synchronous read, independent write port
module frame_luma_ram
  import vga_motion_pkg::*;
(
  input  logic              clk,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  output logic [7:0]        o_rdata
);
  logic [7:0] r_mem [RAM_DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/vga_motion_zone_detector.sv
// vga_motion_zone_detector: per-zone frame-to-frame luma change counting on a 4x4-decimated
// 640x480 image, publishing 12 motion flags once per frame
module vga_motion_zone_detector
  import vga_motion_pkg::*;
#(
  parameter int DIFF_TH  = 24,
  parameter int COUNT_TH = 64,
  parameter int CNT_W    = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pclk,
  input  logic        DE,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  input  logic [15:0] rgb,
  output logic [11:0] motion_flags,
  output logic        frame_done,
  output logic        diff_pixel
);
  logic w_sample, w_report, w_chg, w_done, w_publish, w_count;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [7:0] w_rdata, r_ycur, w_d;
  logic [3:0] r_zone;
  logic r_vld;
  logic [N_ZONES-1:0] w_hit;
  logic [CNT_W-1:0] r_cnt [N_ZONES];
  motion_state_e r_state, w_state_nxt;
  assign w_sample = pclk & DE & (x_pixel[1:0] == 2'b0) & (y_pixel[1:0] == 2'b0);
  assign w_report = pclk & (x_pixel == 10'd0) & (y_pixel == 10'(V_VISIBLE));
  // (y>>2)*160 as shift-add: *128 + *32
  assign w_addr = ({7'b0, y_pixel[9:2]} << 7) + ({7'b0, y_pixel[9:2]} << 5) + {7'b0, x_pixel[9:2]};
  assign w_d = r_ycur > w_rdata ? r_ycur - w_rdata : w_rdata - r_ycur;
  assign w_chg = r_vld & (w_d > 8'(DIFF_TH));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_vld  <= 1'b0;
      r_ycur <= '0;
      r_zone <= '0;
      r_addr <= '0;
    end else begin
      r_vld <= w_sample;
      if (w_sample) begin
        r_ycur <= rgb565_luma(rgb);
        r_zone <= {zone_coord(y_pixel), zone_coord(x_pixel)};
        r_addr <= w_addr;
      end
    end
  frame_luma_ram u_ram (
    .clk     (clk),
    .i_re    (w_sample),
    .i_raddr (w_addr),
    .i_we    (r_vld),
    .i_waddr (r_addr),
    .i_wdata (r_ycur),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_FIRST;
    else r_state <= w_state_nxt;
  always_comb w_state_nxt = w_report ? S_RUN : r_state;
  always_comb begin
    w_done    = w_report;
    w_publish = w_report & (r_state == S_RUN);
    w_count   = w_chg & (r_state == S_RUN);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < N_ZONES; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_ZONES; i++)
        if (w_done) r_cnt[i] <= '0;
        else if (w_count && r_zone == 4'(i) && r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_ZONES; i++) w_hit[i] = int'(r_cnt[i]) >= COUNT_TH;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      motion_flags <= '0;
      frame_done   <= 1'b0;
      diff_pixel   <= 1'b0;
    end else begin
      frame_done <= w_done;
      if (w_publish) motion_flags <= w_hit;
      if (r_vld) diff_pixel <= w_count;
    end
endmodule

// File: tb/tb_vga_motion_zone_detector.sv
// tb_vga_motion_zone_detector: scoreboard bench driving decimated frames and report events
module tb_vga_motion_zone_detector;
  logic clk = 1'b0, reset = 1'b1, pclk = 1'b0, DE = 1'b0;
  logic [9:0] x_pixel = '0, y_pixel = '0;
  logic [15:0] rgb = '0;
  logic [11:0] motion_flags;
  logic frame_done, diff_pixel;
  always #5 clk = ~clk;
  vga_motion_zone_detector dut (
    .clk(clk), .reset(reset), .pclk(pclk), .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .rgb(rgb), .motion_flags(motion_flags), .frame_done(frame_done), .diff_pixel(diff_pixel)
  );
  int n_vec = 0, n_err = 0;
  int m_luma [19200];
  int m_cnt [12];
  bit m_run = 1'b0;
  logic [11:0] m_flags = '0;
  bit q_diff [$];
  logic [11:0] q_flags [$];
  logic [1:0] pipe = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int luma(input logic [15:0] p);
    return 2 * int'(p[15:11]) + int'(p[10:5]) + 2 * int'(p[4:0]);
  endfunction
  task automatic drive(input int x, input int y, input bit de, input logic [15:0] c);
    int a, yl, d, z;
    @(posedge clk); #1;
    pclk = 1'b1; DE = de; x_pixel = 10'(x); y_pixel = 10'(y); rgb = c;
    if (de && x % 4 == 0 && y % 4 == 0) begin
      a = (y / 4) * 160 + x / 4;
      yl = luma(c);
      d = yl - m_luma[a];
      if (d < 0) d = -d;
      z = (y / 160) * 4 + x / 160;
      if (m_run && d > 24 && m_cnt[z] < 2047) m_cnt[z]++;
      m_luma[a] = yl;
      q_diff.push_back(m_run && d > 24);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pclk = 1'b0; DE = 1'b0;
    end
  endtask
  task automatic rect(input int x0, input int y0, input int w, input int h, input logic [15:0] c);
    for (int y = y0; y < y0 + h; y += 4)
      for (int x = x0; x < x0 + w; x += 4) drive(x, y, 1'b1, c);
    idle(1);
  endtask
  task automatic zone_blocks(input logic [15:0] c);
    for (int zy = 0; zy < 3; zy++)
      for (int zx = 0; zx < 4; zx++) rect(zx * 160, zy * 160, 32, 32, c);
  endtask
  task automatic report();
    int i;
    idle(4);
    @(posedge clk); #1;
    pclk = 1'b1; DE = 1'b0; x_pixel = 10'd0; y_pixel = 10'd480; rgb = '0;
    if (m_run)
      for (int z = 0; z < 12; z++) m_flags[z] = m_cnt[z] >= 64;
    q_flags.push_back(m_flags);
    for (int z = 0; z < 12; z++) m_cnt[z] = 0;
    m_run = 1'b1;
    idle(1);
    i = 0;
    while (q_flags.size() > 0 && i < 20) begin
      @(posedge clk);
      i++;
    end
    chk("frame_done_seen", 32'(q_flags.size()), 32'd0);
    idle(2);
  endtask
  // outputs are compared on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (pipe[1]) begin
      chk("diff_queue", 32'(q_diff.size() > 0), 32'd1);
      if (q_diff.size() > 0) chk("diff_pixel", 32'(diff_pixel), 32'(q_diff.pop_front()));
    end
    pipe = {pipe[0], pclk & DE & (x_pixel[1:0] == 2'b0) & (y_pixel[1:0] == 2'b0)};
    if (frame_done) begin
      chk("done_expected", 32'(q_flags.size() > 0), 32'd1);
      if (q_flags.size() > 0) chk("motion_flags", 32'(motion_flags), 32'(q_flags.pop_front()));
    end
  end
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    idle(3);
    chk("rst_flags", 32'(motion_flags), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_diff", 32'(diff_pixel), 32'd0);
    @(negedge clk) reset = 1'b0;
    rect(0, 0, 640, 480, 16'h0000);
    report();
    rect(0, 0, 640, 480, 16'hFFFF);
    report();
    rect(0, 0, 160, 160, 16'hFFFF);
    rect(160, 0, 160, 160, 16'h0000);
    rect(320, 0, 320, 160, 16'hFFFF);
    for (int y = 0; y <= 4; y += 4) begin
      for (int x = 321; x < 480; x += 4) drive(x, y, 1'b1, 16'h0000);
      for (int x = 640; x < 800; x += 4) drive(x, y, 1'b0, 16'h0000);
    end
    report();
    rect(0, 0, 32, 32, 16'h0000);
    report();
    rect(0, 0, 28, 32, 16'hFFFF);
    report();
    zone_blocks(16'h0000);
    report();
    zone_blocks(16'h0300);
    report();
    zone_blocks(16'h0620);
    report();
    rect(0, 192, 640, 8, 16'h0000);
    idle(4);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_rst_flags", 32'(motion_flags), 32'd0);
    chk("async_rst_done", 32'(frame_done), 32'd0);
    chk("async_rst_diff", 32'(diff_pixel), 32'd0);
    m_run = 1'b0;
    m_flags = '0;
    for (int z = 0; z < 12; z++) m_cnt[z] = 0;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    zone_blocks(16'h0000);
    report();
    zone_blocks(16'hFFFF);
    report();
    idle(4);
    chk("diff_drain", 32'(q_diff.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
